lsu_mem_stage: RTL and testbench

Load/store stage directly downstream of the ALU.
- Takes the ALU address result (the ALU_LW_SW add) plus the rs2 store data and performs byte, halfword and word memory accesses over a req/ack handshake to data memory.
- Returns the aligned, sign- or zero-extended load value to writeback.
- Holds `busy` so the control unit can stall the PC while an access is outstanding.

---
 rtl/lsu_mem_stage_pkg.sv | 46 ++++
 rtl/lsu_mem_stage_if.sv | 28 ++
 rtl/lsu_mem_stage_load_extract.sv | 34 +++
 rtl/lsu_mem_stage.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_pkg
// Description : Shared constants, error codes and decode helpers for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_mem_stage_pkg;

    localparam int DATA_LEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_ERR_OK       = 2'd0,
        LSU_ERR_MISALIGN = 2'd1,
        LSU_ERR_TIMEOUT  = 2'd2,
        LSU_ERR_ILLEGAL  = 2'd3
    } lsu_err_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Bytes never misalign; halves need off[0]==0; words need off==0.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_if
// Description : Data-memory req/ack bus between the LSU and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_stage_if;

    logic                                    mem_req;
    logic                                    mem_we;
    logic [lsu_mem_stage_pkg::DATA_LEN-1:0]  mem_addr;
    logic [3:0]                              mem_wstrb;
    logic [lsu_mem_stage_pkg::DATA_LEN-1:0]  mem_wdata;
    logic                                    mem_ack;
    logic [lsu_mem_stage_pkg::DATA_LEN-1:0]  mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/lsu_mem_stage_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_load_extract
// Description : Selects the addressed byte/half of a read word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage_load_extract
    import lsu_mem_stage_pkg::*;
(
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    input  logic [1:0]          off_i,
    input  logic [2:0]          funct3_i,
    output logic [DATA_LEN-1:0] rdata_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = mem_rdata_i[{off_i, 3'b000} +: 8];
    assign w_half = mem_rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        rdata_o = mem_rdata_i;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{w_byte[7]}}, w_byte};
            F3_LH:   rdata_o = {{16{w_half[15]}}, w_half};
            F3_LBU:  rdata_o = {24'd0, w_byte};
            F3_LHU:  rdata_o = {16'd0, w_half};
            default: rdata_o = mem_rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : Load/store stage: byte/half/word accesses over req/ack memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic [2:0]          funct3_i,
    input  logic [DATA_LEN-1:0] addr_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0]          err_o,
    output logic [DATA_LEN-1:0] rdata_o,
    lsu_mem_stage_if.master     mem_bus
);

    localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYC - 1);

    logic [1:0]          state_q, state_d;
    logic [7:0]          cnt_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;
    logic [DATA_LEN-1:0] maddr_q;
    logic [3:0]          wstrb_q;
    logic [DATA_LEN-1:0] wdata_q;
    lsu_err_e            err_q;
    logic [DATA_LEN-1:0] rdata_q;

    logic                w_illegal, w_noop, w_misalign, w_timeout, w_mem_req;
    logic [3:0]          w_strb;
    logic [DATA_LEN-1:0] w_wdata, w_load;

    assign w_illegal  = (mem_read_i && mem_write_i) || !f3_legal(funct3_i) ||
                        (mem_write_i && funct3_i[2]);
    assign w_noop     = !mem_read_i && !mem_write_i;
    assign w_misalign = f3_misaligned(funct3_i, addr_i[1:0]);
    assign w_timeout  = (cnt_q == c_to_last);

    // Store data is replicated across lanes so memory can pick by strobe alone.
    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << addr_i[1:0];
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_mem_stage_load_extract u_extract (
        .mem_rdata_i (mem_bus.mem_rdata),
        .off_i       (off_q),
        .funct3_i    (f3_q),
        .rdata_o     (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = (w_illegal || w_noop || w_misalign) ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_bus.mem_ack || w_timeout) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        done_o    = (state_q == ST_RESP);
        w_mem_req = (state_q == ST_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            maddr_q <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            err_q   <= LSU_ERR_OK;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    if (w_illegal) begin
                        err_q <= LSU_ERR_ILLEGAL;
                    end else if (w_noop) begin
                        err_q   <= LSU_ERR_OK;
                        rdata_q <= '0;
                    end else if (w_misalign) begin
                        err_q <= LSU_ERR_MISALIGN;
                    end else begin
                        we_q    <= mem_write_i;
                        f3_q    <= funct3_i;
                        off_q   <= addr_i[1:0];
                        maddr_q <= {addr_i[DATA_LEN-1:2], 2'b00};
                        wstrb_q <= mem_write_i ? w_strb : 4'b0000;
                        wdata_q <= w_wdata;
                        cnt_q   <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_bus.mem_ack) begin
                        err_q <= LSU_ERR_OK;
                        if (!we_q) rdata_q <= w_load;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (w_timeout) err_q <= LSU_ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_o             = err_q;
    assign rdata_o           = rdata_q;
    assign mem_bus.mem_req   = w_mem_req;
    assign mem_bus.mem_we    = we_q;
    assign mem_bus.mem_addr  = maddr_q;
    assign mem_bus.mem_wstrb = wstrb_q;
    assign mem_bus.mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_stage
// Description : Randomized self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o;
    logic [1:0]  err_o;
    logic [31:0] rdata_o;

    lsu_mem_stage_if bus();

    lsu_mem_stage #(.TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        check_en = 1'b0;
    logic        exp_busy, exp_done, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wd, exp_rdata;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_err;
    logic [31:0] m_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input int off, input logic [2:0] f3);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b > 127)   ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h > 32767) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", {31'd0, busy_o}, {31'd0, exp_busy});
            chk("done", {31'd0, done_o}, {31'd0, exp_done});
            chk("mem_req", {31'd0, bus.mem_req}, {31'd0, exp_req});
            chk("rdata", rdata_o, exp_rdata);
            if (exp_req) begin
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, exp_we});
                chk("mem_addr", bus.mem_addr, exp_addr);
                chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, exp_strb});
                if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wd);
            end
            if (exp_done) chk("err", {30'd0, err_o}, {30'd0, exp_err});
        end
    end

    task automatic drive_junk(input logic junk);
        start_i = junk;
        if (junk) begin
            mem_read_i  = 1'($urandom);
            mem_write_i = 1'($urandom);
            funct3_i    = 3'($urandom);
            addr_i      = $urandom;
            wdata_i     = $urandom;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        start_i  = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
    endtask

    // One access from start to its done cycle; lit_mask: [0] strobe/wdata, [1] err, [2] rdata.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                           input int wait_ack, input logic junk, input logic [2:0] lit_mask,
                           input logic [3:0] lit_strb, input logic [31:0] lit_wd,
                           input logic [1:0] lit_err, input logic [31:0] lit_rd);
        logic       legal, access, acked;
        int         size;
        logic [1:0] e;
        @(posedge clk); #1;
        start_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
        funct3_i = f3; addr_i = addr; wdata_i = wd;
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
        size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal  = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(rd && wr) && !(wr && f3[2]);
        access = 1'b0; acked = 1'b0; e = 2'd0;
        if (!legal)                  e = 2'd3;
        else if (!rd && !wr)         m_rdata = 32'd0;
        else if ((addr % size) != 0) e = 2'd1;
        else                         access = 1'b1;
        exp_we   = wr;
        exp_addr = addr - (addr % 4);
        exp_strb = wr ? 4'(((1 << size) - 1) << (addr % 4)) : 4'd0;
        exp_wd   = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        @(posedge clk); #1; drive_junk(junk);
        if (access) begin
            if (lit_mask[0]) begin
                chk("lit_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, lit_strb});
                chk("lit_wdata", bus.mem_wdata, lit_wd);
            end
            for (int k = 0; k < T && !acked; k++) begin
                exp_busy = 1'b1; exp_done = 1'b0; exp_req = 1'b1;
                acked = (k == wait_ack);
                bus.mem_ack = acked;
                bus.mem_rdata = acked ? word : $urandom;
                @(posedge clk); #1; drive_junk(junk);
            end
            bus.mem_ack = 1'b0;
            if (!acked) e = 2'd2;
            else if (rd) m_rdata = m_load(word, int'(addr[1:0]), f3);
        end
        exp_busy = 1'b1; exp_done = 1'b1; exp_req = 1'b0;
        exp_err = e; exp_rdata = m_rdata;
        if (lit_mask[1]) chk("lit_err", {30'd0, err_o}, {30'd0, lit_err});
        if (lit_mask[2]) chk("lit_rdata", rdata_o, lit_rd);
    endtask

    task automatic reset_mid_req();
        @(posedge clk); #1;
        start_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
        funct3_i = 3'd2; addr_i = 32'h200; wdata_i = 32'd0;
        bus.mem_ack = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        exp_busy = 1'b1; exp_req = 1'b1; exp_we = 1'b0;
        exp_addr = 32'h200; exp_strb = 4'd0;
        #5 rst = 1'b1;
        #1;
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        m_rdata = 32'd0; exp_rdata = 32'd0; exp_err = 2'd0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
        exp_addr = 32'd0; exp_wd = 32'd0; exp_strb = 4'd0; exp_err = 2'd0;
        exp_rdata = 32'd0; m_rdata = 32'd0;
        #2;
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_done", {31'd0, done_o}, 32'd0);
        chk("reset_req", {31'd0, bus.mem_req}, 32'd0);
        chk("reset_err", {30'd0, err_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        #10 rst = 1'b0;
        check_en = 1'b1;

        run_txn(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'd0, 0, 1'b0, 3'b111,
                4'hF, 32'hDEADBEEF, 2'd0, 32'h0);
        run_txn(1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 32'd0, 0, 1'b0, 3'b011,
                4'h8, 32'hA5A5A5A5, 2'd0, 32'h0);
        run_txn(1'b1, 1'b0, 3'd0, 32'h102, 32'd0, 32'h1280FF00, 0, 1'b0, 3'b110,
                4'h0, 32'h0, 2'd0, 32'hFFFFFF80);
        run_txn(1'b1, 1'b0, 3'd4, 32'h102, 32'd0, 32'h1280FF00, 1, 1'b0, 3'b110,
                4'h0, 32'h0, 2'd0, 32'h00000080);
        run_txn(1'b1, 1'b0, 3'd5, 32'h102, 32'd0, 32'h1280FF00, 2, 1'b0, 3'b110,
                4'h0, 32'h0, 2'd0, 32'h00001280);
        run_txn(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 32'd0, 0, 1'b0, 3'b010,
                4'h0, 32'h0, 2'd1, 32'h0);
        run_txn(1'b0, 1'b1, 3'd1, 32'h003, 32'h1234, 32'd0, 0, 1'b0, 3'b010,
                4'h0, 32'h0, 2'd1, 32'h0);
        run_txn(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, 32'd0, 99, 1'b1, 3'b010,
                4'h0, 32'h0, 2'd2, 32'h0);
        idle_cycle();
        reset_mid_req();
        run_txn(1'b1, 1'b0, 3'd2, 32'h104, 32'd0, 32'h11223344, 1, 1'b0, 3'b110,
                4'h0, 32'h0, 2'd0, 32'h11223344);
        run_txn(1'b1, 1'b1, 3'd2, 32'h108, 32'd0, 32'd0, 0, 1'b0, 3'b010,
                4'h0, 32'h0, 2'd3, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic       rd, wr;
            logic [2:0] f3;
            int         sel;
            sel = $urandom_range(0, 9);
            rd = (sel >= 2 && sel <= 5) || sel == 0;
            wr = (sel >= 6) || sel == 0;
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
                 (wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4)));
            if (!wr && f3 == 3'd3) f3 = 3'd5;
            run_txn(rd, wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, T + 1),
                    1'($urandom), 3'b000, 4'h0, 32'h0, 2'd0, 32'h0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
